instr_encoder_loader: RTL and testbench

Sequential instruction encoder and program loader that sits between a testbench or boot source and the single-cycle CPU's instruction memory. It packs decoded MIPS instruction fields (R, I, J formats) into 32-bit words, the inverse of the control decoder's field split. It writes each word into instruction memory at consecutive word addresses over a write/ack handshake. Loading is started by a pulse and ends on an END token or on capacity overflow.

---
 rtl/instr_encoder_loader.sv | 178 +++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : instr_encoder_loader
//  Description : Packs decoded MIPS instruction fields (R/I/J formats) into
//                32-bit words and writes them into instruction memory at
//                consecutive word addresses over a write/ack handshake.
//                A start pulse begins a load. The load ends on an END token
//                or when the memory capacity has been filled.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_encoder_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  input  logic              im_ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  // Format codes carried on in_fmt
  localparam logic [1:0] c_fmt_r   = 2'd0;
  localparam logic [1:0] c_fmt_i   = 2'd1;
  localparam logic [1:0] c_fmt_j   = 2'd2;
  localparam logic [1:0] c_fmt_end = 2'd3;

  // First word address of a load, reduced to the pointer width
  localparam logic [ADDR_W-1:0] c_base_addr = ADDR_W'(BASE_ADDR);
  // Word count at which memory is full (2^ADDR_W)
  localparam logic [ADDR_W:0]   c_capacity  = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;

  logic                r_we;
  logic                w_we_nx;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_nx;
  logic [31:0]         r_wdata;
  logic [31:0]         w_wdata_nx;
  logic                r_done;
  logic                w_done_nx;
  logic                r_err;
  logic                w_err_nx;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W:0]     w_count_nx;

  logic [31:0]         w_encoded;
  logic [ADDR_W:0]     w_count_inc;

  // Pack the incoming field tuple into a 32-bit instruction word
  always_comb begin
    w_encoded = 32'd0;
    case (in_fmt)
      c_fmt_r: w_encoded = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
      c_fmt_i: w_encoded = {in_op, in_rs, in_rt, in_imm};
      c_fmt_j: w_encoded = {in_op, in_target};
      default: w_encoded = 32'd0;
    endcase
  end

  assign w_count_inc = r_count + {{ADDR_W{1'b0}}, 1'b1};

  // Next-state and next registered-output logic for the load sequencer
  always_comb begin
    w_state_nx = r_state;
    w_we_nx    = r_we;
    w_addr_nx  = r_addr;
    w_wdata_nx = r_wdata;
    w_done_nx  = r_done;
    w_err_nx   = r_err;
    w_count_nx = r_count;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_ACCEPT;
          w_addr_nx  = c_base_addr;
          w_count_nx = '0;
          w_done_nx  = 1'b0;
          w_err_nx   = 1'b0;
        end
      end

      S_ACCEPT: begin
        if (in_valid) begin
          if (in_fmt == c_fmt_end) begin
            // END token: finish without writing anything
            w_done_nx  = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_wdata_nx = w_encoded;
            w_we_nx    = 1'b1;
            w_state_nx = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        // Address and data stay put until memory acknowledges
        if (im_ack) begin
          w_we_nx    = 1'b0;
          w_addr_nx  = r_addr + ADDR_W'(1);
          w_count_nx = w_count_inc;
          if (w_count_inc == c_capacity) begin
            w_err_nx   = 1'b1;
            w_done_nx  = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_state_nx = S_ACCEPT;
          end
        end
      end

      default: begin
        w_state_nx = S_IDLE;
        w_we_nx    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any pending write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= c_base_addr;
      r_wdata <= 32'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nx;
      r_we    <= w_we_nx;
      r_addr  <= w_addr_nx;
      r_wdata <= w_wdata_nx;
      r_done  <= w_done_nx;
      r_err   <= w_err_nx;
      r_count <= w_count_nx;
    end
  end

  assign in_ready = (r_state == S_ACCEPT);
  assign busy     = (r_state != S_IDLE);
  assign im_we    = r_we;
  assign im_addr  = r_addr;
  assign im_wdata = r_wdata;
  assign done     = r_done;
  assign err      = r_err;
  assign count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_instr_encoder_loader
//  Description : Directed, table-driven bench for instr_encoder_loader with a
//                default-size instance and a tiny (ADDR_W=2, BASE_ADDR=3) one.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_encoder_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        start_s;
  logic        in_valid;
  logic [1:0]  in_fmt;
  logic [5:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        im_ack;
  logic        im_ack_s;

  logic        in_ready, im_we, busy, done, err;
  logic [9:0]  im_addr;
  logic [31:0] im_wdata;
  logic [10:0] count;

  logic        in_ready_s, im_we_s, busy_s, done_s, err_s;
  logic [1:0]  im_addr_s;
  logic [31:0] im_wdata_s;
  logic [2:0]  count_s;

  int checks = 0;
  int errors = 0;

  instr_encoder_loader #(.ADDR_W(10), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_fmt(in_fmt), .in_op(in_op), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target), .im_we(im_we), .im_addr(im_addr),
    .im_wdata(im_wdata), .im_ack(im_ack), .busy(busy), .done(done),
    .err(err), .count(count)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(3)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .in_valid(in_valid),
    .in_ready(in_ready_s), .in_fmt(in_fmt), .in_op(in_op), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target), .im_we(im_we_s), .im_addr(im_addr_s),
    .im_wdata(im_wdata_s), .im_ack(im_ack_s), .busy(busy_s), .done(done_s),
    .err(err_s), .count(count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input vec_t v);
    in_fmt = v.fmt; in_op = v.op; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd;
    in_shamt = v.sh; in_funct = v.funct; in_imm = v.imm; in_target = v.target;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_ready", 32'(in_ready), 32'd1);
    chk("start_busy",     32'(busy),     32'd1);
    chk("start_done_clr", 32'(done),     32'd0);
    chk("start_count",    32'(count),    32'd0);
  endtask

  // Present one tuple, check the write it produces, then acknowledge it
  task automatic write_one(input vec_t v, input int exp_addr, input int exp_cnt);
    drive_vec(v);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("wr_we",       32'(im_we),    32'd1);
    chk("wr_ready_lo", 32'(in_ready), 32'd0);
    chk("wr_addr",     32'(im_addr),  32'(exp_addr));
    chk("wr_data",     im_wdata,      v.exp);
    im_ack = 1'b1;
    tick();
    im_ack = 1'b0;
    chk("ack_we_lo",   32'(im_we),    32'd0);
    chk("ack_ready",   32'(in_ready), 32'd1);
    chk("ack_count",   32'(count),    32'(exp_cnt));
  endtask

  task automatic send_end(input int exp_cnt);
    in_fmt   = 2'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("end_done",  32'(done),  32'd1);
    chk("end_busy",  32'(busy),  32'd0);
    chk("end_we",    32'(im_we), 32'd0);
    chk("end_count", 32'(count), 32'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vr;
    // fmt  op     rs   rt   rd   sh   funct  imm      target        expected
    vecs[0] = '{2'd0, 6'h00, 5'd1,  5'd2,  5'd3,  5'd0,  6'h21, 16'h0000, 26'h0000000, 32'h00221821};
    vecs[1] = '{2'd1, 6'h08, 5'd0,  5'd8,  5'd0,  5'd0,  6'h00, 16'h0005, 26'h0000000, 32'h20080005};
    vecs[2] = '{2'd2, 6'h02, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 26'h0000010, 32'h08000010};
    vecs[3] = '{2'd0, 6'h00, 5'd31, 5'd0,  5'd0,  5'd0,  6'h08, 16'h0000, 26'h0000000, 32'h03E00008};
    vecs[4] = '{2'd0, 6'h3F, 5'd0,  5'd0,  5'd0,  5'd31, 6'h00, 16'hFFFF, 26'h3FFFFFF, 32'h000007C0};
    vecs[5] = '{2'd1, 6'h23, 5'd29, 5'd31, 5'd31, 5'd31, 6'h3F, 16'h8000, 26'h3FFFFFF, 32'h8FBF8000};
    vecs[6] = '{2'd2, 6'h03, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 32'h0FFFFFFF};

    rst_n = 1'b0; start = 1'b0; start_s = 1'b0; in_valid = 1'b0;
    im_ack = 1'b0; im_ack_s = 1'b0;
    drive_vec(vecs[0]);
    tick(); tick();
    rst_n = 1'b1;

    // Reset values of both instances
    chk("rst_ready",   32'(in_ready),  32'd0);
    chk("rst_we",      32'(im_we),     32'd0);
    chk("rst_addr",    32'(im_addr),   32'd0);
    chk("rst_wdata",   im_wdata,       32'd0);
    chk("rst_busy",    32'(busy),      32'd0);
    chk("rst_done",    32'(done),      32'd0);
    chk("rst_err",     32'(err),       32'd0);
    chk("rst_count",   32'(count),     32'd0);
    chk("rst_s_addr",  32'(im_addr_s), 32'd3);
    chk("rst_s_count", 32'(count_s),   32'd0);

    // Each table entry as its own one-word load
    for (int i = 0; i < 7; i++) begin
      do_start();
      write_one(vecs[i], 0, 1);
      send_end(1);
    end

    // Two-word load: I then J at consecutive addresses
    do_start();
    write_one(vecs[1], 0, 1);
    write_one(vecs[2], 1, 2);
    send_end(2);

    // Delayed acknowledge: word held for four cycles
    do_start();
    drive_vec(vecs[3]);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("hold_we",    32'(im_we),    32'd1);
      chk("hold_addr",  32'(im_addr),  32'd0);
      chk("hold_data",  im_wdata,      32'h03E00008);
      chk("hold_ready", 32'(in_ready), 32'd0);
      if (k == 3) im_ack = 1'b1;
      tick();
    end
    im_ack = 1'b0;
    chk("hold_after_we",    32'(im_we),    32'd0);
    chk("hold_after_ready", 32'(in_ready), 32'd1);
    chk("hold_after_count", 32'(count),    32'd1);
    // Acknowledge while in ACCEPT has no effect
    im_ack = 1'b1;
    tick();
    im_ack = 1'b0;
    chk("stray_ack_count", 32'(count),    32'd1);
    chk("stray_ack_ready", 32'(in_ready), 32'd1);
    send_end(1);

    // Small instance: BASE_ADDR=3 wraps through 0, overflow at 4 words
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    chk("s_ready", 32'(in_ready_s), 32'd1);
    for (int i = 0; i < 4; i++) begin
      vr = vecs[0];
      vr.rd = 5'(i);
      vr.exp = 32'h00220021 | (32'(i) << 11);
      drive_vec(vr);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("s_we",   32'(im_we_s),   32'd1);
      chk("s_addr", 32'(im_addr_s), 32'((3 + i) % 4));
      chk("s_data", im_wdata_s,     vr.exp);
      im_ack_s = 1'b1;
      tick();
      im_ack_s = 1'b0;
      chk("s_count", 32'(count_s), 32'(i + 1));
    end
    chk("s_err",   32'(err_s),      32'd1);
    chk("s_done",  32'(done_s),     32'd1);
    chk("s_busy",  32'(busy_s),     32'd0);
    chk("s_ready_lo", 32'(in_ready_s), 32'd0);
    // Fifth tuple is offered but never taken
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    chk("s_fifth_we",    32'(im_we_s),    32'd0);
    chk("s_fifth_ready", 32'(in_ready_s), 32'd0);
    chk("s_fifth_count", 32'(count_s),    32'd4);

    // Reset while a write is pending
    do_start();
    drive_vec(vecs[5]);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mid_we", 32'(im_we), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_we",     32'(im_we),     32'd0);
    chk("mrst_ready",  32'(in_ready),  32'd0);
    chk("mrst_busy",   32'(busy),      32'd0);
    chk("mrst_addr",   32'(im_addr),   32'd0);
    chk("mrst_wdata",  im_wdata,       32'd0);
    chk("mrst_done",   32'(done),      32'd0);
    chk("mrst_err",    32'(err),       32'd0);
    chk("mrst_count",  32'(count),     32'd0);
    chk("mrst_s_addr", 32'(im_addr_s), 32'd3);
    chk("mrst_s_err",  32'(err_s),     32'd0);
    do_start();
    write_one(vecs[2], 0, 1);

    // start in WRITE and in ACCEPT is ignored
    drive_vec(vecs[1]);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_we",   32'(im_we),   32'd1);
    chk("busy_start_addr", 32'(im_addr), 32'd1);
    im_ack = 1'b1;
    tick();
    im_ack = 1'b0;
    chk("busy_start_count", 32'(count), 32'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("acc_start_count", 32'(count),    32'd2);
    chk("acc_start_ready", 32'(in_ready), 32'd1);
    // start together with END: END wins, start dropped
    start = 1'b1;
    send_end(2);
    start = 1'b0;
    // in_valid while idle is ignored
    drive_vec(vecs[0]);
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    chk("idle_valid_ready", 32'(in_ready), 32'd0);
    chk("idle_valid_we",    32'(im_we),    32'd0);
    chk("idle_valid_count", 32'(count),    32'd2);
    chk("idle_valid_done",  32'(done),     32'd1);
    chk("idle_valid_busy",  32'(busy),     32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
